// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the register-file bus between issue/writeback (master) and the
// register file (slave).
//
// Signals (direction as seen from the slave):
//   write_en, write_addr, write_data   in   writeback port
//   read_addr1, read_addr2             in   read port addresses
//   reserve_en, reserve_addr           in   scoreboard reservation
//   read_data1, read_data2             out  combinational read data
//   busy1, busy2                       out  pending-writeback flags per read port
//   reserve_err                        out  registered double-reservation pulse
// -----------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              reserve_en;
    logic [ADDR_W-1:0] reserve_addr;
    logic              busy1;
    logic              busy2;
    logic              reserve_err;

    modport master (
        output write_en, write_addr, write_data,
        output read_addr1, read_addr2,
        output reserve_en, reserve_addr,
        input  read_data1, read_data2,
        input  busy1, busy2, reserve_err
    );

    modport slave (
        input  write_en, write_addr, write_data,
        input  read_addr1, read_addr2,
        input  reserve_en, reserve_addr,
        output read_data1, read_data2,
        output busy1, busy2, reserve_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// General-purpose register file: two combinational read ports with
// write-to-read bypass, one synchronous write port, optional hardwired-zero R0,
// and a per-register busy scoreboard used by issue logic to spot RAW hazards.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   bus       reg_file_sb_if.slave (write, read, reserve, busy, reserve_err)
//   wb_count  out  [15:0] saturating count of accepted writes
//                  (present only when REG_FILE_STATS_EN is defined)
//
// Optional feature macro: REG_FILE_STATS_EN
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_sb_if.slave       bus
`ifdef REG_FILE_STATS_EN
    ,
    output logic [15:0]        wb_count
`endif
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              reserve_err_q;

    logic              wr_ok;
    logic              rsv_ok;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    // A write or reservation aimed at a hardwired R0 is dropped entirely.
    // Writes are also masked during reset so the bypass cannot leak write_data
    // while the array is being held at zero.
    assign wr_ok  = bus.write_en && !rst &&
                    !((ZERO_REG != 0) && (bus.write_addr == '0));
    assign rsv_ok = bus.reserve_en &&
                    !((ZERO_REG != 0) && (bus.reserve_addr == '0));

    assign rd_addr[0] = bus.read_addr1;
    assign rd_addr[1] = bus.read_addr2;

    // Read ports: array value, overridden by a same-cycle write (which also
    // resolves the hazard, so busy drops), overridden again by hardwired R0.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: every output of a combinational block gets a default
            // before any conditional override, otherwise a latch is inferred.
            rd_data[p] = mem[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if (wr_ok && (bus.write_addr == rd_addr[p])) begin
                rd_data[p] = bus.write_data;
                rd_busy[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.read_data1  = rd_data[0];
    assign bus.read_data2  = rd_data[1];
    assign bus.busy1       = rd_busy[0];
    assign bus.busy2       = rd_busy[1];
    assign bus.reserve_err = reserve_err_q;

    // Writeback clears, reservation sets; the set comes last so a younger
    // instruction's reservation survives a same-cycle writeback of an older one.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[bus.write_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[bus.reserve_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset explicitly because software expects
            // every register to read zero after reset; this keeps it in flops.
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            busy          <= '0;
            reserve_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (wr_ok)
                mem[bus.write_addr] <= bus.write_data;
            busy          <= busy_nxt;
            // A same-cycle writeback to the same register retires the old
            // reservation, so the new one is not a double booking.
            reserve_err_q <= rsv_ok && busy[bus.reserve_addr] &&
                             !(bus.write_en && (bus.write_addr == bus.reserve_addr));
        end
    end

`ifdef REG_FILE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_count <= '0;
        else if (wr_ok && (wb_count != 16'hFFFF))
            wb_count <= wb_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed self-checking bench for reg_file_sb (default parameters,
// ZERO_REG=1). Expected values are queued when stimulus is applied and popped
// and compared by check() at the sampling point.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam int SEL_RD1  = 0;
    localparam int SEL_RD2  = 1;
    localparam int SEL_BSY1 = 2;
    localparam int SEL_BSY2 = 3;
    localparam int SEL_ERR  = 4;
    localparam int SEL_WBC  = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] want;
    } exp_t;

    logic clk;
    logic rst;
    reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef REG_FILE_STATS_EN
    logic [15:0] wb_count;
`endif

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef REG_FILE_STATS_EN
        ,
        .wb_count (wb_count)
`endif
    );

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] ref_mem [8];
    int          exp_wb = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observed(int sel);
        case (sel)
            SEL_RD1:  return bus.read_data1;
            SEL_RD2:  return bus.read_data2;
            SEL_BSY1: return {15'd0, bus.busy1};
            SEL_BSY2: return {15'd0, bus.busy2};
            SEL_ERR:  return {15'd0, bus.reserve_err};
`ifdef REG_FILE_STATS_EN
            SEL_WBC:  return wb_count;
`endif
            default:  return 16'hXXXX;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] want);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.want = want;
        sb_q.push_back(e);
    endtask

    task automatic expect_wb(input string tag);
`ifdef REG_FILE_STATS_EN
        expect_val(tag, SEL_WBC, 16'(exp_wb));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Pops every pending expectation and compares it with the live outputs.
    task automatic check();
        exp_t        e;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observed(e.sel);
            n_cmp++;
            assert (obs === e.want) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.want);
            end
        end
    endtask

    task automatic idle();
        bus.write_en     = 1'b0;
        bus.write_addr   = '0;
        bus.write_data   = '0;
        bus.reserve_en   = 1'b0;
        bus.reserve_addr = '0;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [15:0] d);
        bus.write_en   = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
        if (a != 3'd0) begin
            ref_mem[a] = d;
            exp_wb++;
        end
    endtask

    task automatic drive_reserve(input logic [2:0] a);
        bus.reserve_en   = 1'b1;
        bus.reserve_addr = a;
    endtask

    // Advance one clock; returns on the falling edge with inputs idle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        // ---- reset holds everything at zero, even with write/reserve active
        rst = 1'b1;
        bus.read_addr1 = 3'd3;
        bus.read_addr2 = 3'd3;
        bus.write_en     = 1'b1;
        bus.write_addr   = 3'd3;
        bus.write_data   = 16'hAAAA;
        bus.reserve_en   = 1'b1;
        bus.reserve_addr = 3'd3;
        #1;
        expect_val("rst_rd1", SEL_RD1, 16'h0000);
        expect_val("rst_rd2", SEL_RD2, 16'h0000);
        expect_val("rst_busy1", SEL_BSY1, 16'd0);
        expect_val("rst_busy2", SEL_BSY2, 16'd0);
        check();
        @(posedge clk);
        @(negedge clk);
        #1;
        expect_val("rst_edge_rd1", SEL_RD1, 16'h0000);
        expect_val("rst_edge_busy1", SEL_BSY1, 16'd0);
        expect_val("rst_edge_err", SEL_ERR, 16'd0);
        expect_wb("rst_wb_count");
        check();
        idle();
        rst = 1'b0;
        #1;
        expect_val("post_rst_rd1", SEL_RD1, 16'h0000);
        expect_val("post_rst_busy1", SEL_BSY1, 16'd0);
        check();

        // ---- write R3 with bypass, then read back from the array
        drive_write(3'd3, 16'd35);
        #1;
        expect_val("bypass_r3", SEL_RD1, 16'd35);
        check();
        tick();
        bus.read_addr1 = 3'd3;
        drive_write(3'd4, 16'd47);
        bus.read_addr2 = 3'd4;
        #1;
        expect_val("read_r3", SEL_RD1, 16'd35);
        expect_val("bypass_r4", SEL_RD2, 16'd47);
        check();
        tick();
        bus.read_addr1 = 3'd4;
        #1;
        expect_val("read_r4_p1", SEL_RD1, 16'd47);
        expect_val("read_r4_p2", SEL_RD2, 16'd47);
        check();

        // ---- hardwired R0 ignores writes and reservations
        bus.read_addr1 = 3'd0;
        drive_write(3'd0, 16'hBEEF);
        drive_reserve(3'd0);
        #1;
        expect_val("r0_bypass_rd1", SEL_RD1, 16'h0000);
        expect_val("r0_bypass_busy1", SEL_BSY1, 16'd0);
        check();
        tick();
        drive_reserve(3'd0);
        #1;
        expect_val("r0_rd1", SEL_RD1, 16'h0000);
        expect_val("r0_busy1", SEL_BSY1, 16'd0);
        expect_val("r0_err", SEL_ERR, 16'd0);
        check();
        tick();
        #1;
        expect_val("r0_err_again", SEL_ERR, 16'd0);
        check();

        // ---- scoreboard on R5
        bus.read_addr1 = 3'd5;
        drive_reserve(3'd5);
        #1;
        expect_val("r5_busy_pre", SEL_BSY1, 16'd0);
        check();
        tick();
        #1;
        expect_val("r5_busy_set", SEL_BSY1, 16'd1);
        expect_val("r5_err_first", SEL_ERR, 16'd0);
        check();
        drive_write(3'd5, 16'd256);
        #1;
        expect_val("r5_bypass_rd1", SEL_RD1, 16'd256);
        expect_val("r5_bypass_busy1", SEL_BSY1, 16'd0);
        check();
        tick();
        #1;
        expect_val("r5_after_wb_busy1", SEL_BSY1, 16'd0);
        expect_val("r5_after_wb_rd1", SEL_RD1, 16'd256);
        check();
        drive_reserve(3'd5);
        tick();
        #1;
        expect_val("r5_rebusy", SEL_BSY1, 16'd1);
        expect_val("r5_rebusy_err", SEL_ERR, 16'd0);
        check();
        drive_reserve(3'd5);
        tick();
        #1;
        expect_val("r5_double_err", SEL_ERR, 16'd1);
        expect_val("r5_double_busy", SEL_BSY1, 16'd1);
        check();
        tick();
        #1;
        expect_val("r5_err_one_cycle", SEL_ERR, 16'd0);
        check();

        // ---- same-cycle reserve + write on R6: set wins, no error
        bus.read_addr1 = 3'd6;
        drive_write(3'd6, 16'h1234);
        drive_reserve(3'd6);
        #1;
        expect_val("r6_bypass_rd1", SEL_RD1, 16'h1234);
        expect_val("r6_bypass_busy1", SEL_BSY1, 16'd0);
        check();
        tick();
        #1;
        expect_val("r6_rd1", SEL_RD1, 16'h1234);
        expect_val("r6_busy1", SEL_BSY1, 16'd1);
        expect_val("r6_err", SEL_ERR, 16'd0);
        check();
        // R6 is busy, but the same-cycle writeback retires that reservation
        drive_write(3'd6, 16'h5678);
        drive_reserve(3'd6);
        tick();
        #1;
        expect_val("r6_rewb_err", SEL_ERR, 16'd0);
        expect_val("r6_rewb_busy1", SEL_BSY1, 16'd1);
        expect_val("r6_rewb_rd1", SEL_RD1, 16'h5678);
        check();

        // ---- fill R1..R7 with random data and read back through both ports
        for (int i = 1; i < 8; i++) begin
            drive_write(3'(i), 16'($urandom));
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            bus.read_addr1 = 3'(i);
            bus.read_addr2 = 3'(i ^ 3);
            #1;
            expect_val($sformatf("fill_rd1_r%0d", i), SEL_RD1, ref_mem[i]);
            expect_val($sformatf("fill_rd2_r%0d", i ^ 3), SEL_RD2, ref_mem[i ^ 3]);
            check();
        end
        bus.read_addr2 = 3'd6;
        bus.read_addr1 = 3'd6;
        #1;
        expect_val("same_reg_p1", SEL_RD1, ref_mem[6]);
        expect_val("same_reg_p2", SEL_RD2, ref_mem[6]);
        expect_wb("wb_count_fill");
        check();

        // ---- reset in the middle of a cycle clears everything at once
        drive_reserve(3'd2);
        tick();
        drive_reserve(3'd7);
        drive_write(3'd2, 16'd9);
        tick();
        drive_reserve(3'd7);
        tick();
        bus.read_addr1 = 3'd2;
        bus.read_addr2 = 3'd7;
        #1;
        expect_val("pre_rst_rd1", SEL_RD1, 16'd9);
        expect_val("pre_rst_busy2", SEL_BSY2, 16'd1);
        expect_val("pre_rst_err", SEL_ERR, 16'd1);
        expect_wb("pre_rst_wb_count");
        check();
        #2;
        rst = 1'b1;
        exp_wb = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        #1;
        expect_val("mid_rst_rd1", SEL_RD1, 16'h0000);
        expect_val("mid_rst_busy1", SEL_BSY1, 16'd0);
        expect_val("mid_rst_busy2", SEL_BSY2, 16'd0);
        expect_val("mid_rst_err", SEL_ERR, 16'd0);
        expect_wb("mid_rst_wb_count");
        check();
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_val("after_rst_rd2", SEL_RD2, 16'h0000);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised general-purpose register file with two combinational read ports and one synchronous write port. Adds write-to-read bypass, an optional hardwired-zero R0, and a per-register busy scoreboard so issue logic can detect pending writebacks (RAW hazards). Sits between decode/issue (reads, reservations) and writeback (writes) in the 16-bit RISC datapath.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = R0 reads 0, ignores writes, is never busy; 0 = R0 is an ordinary register

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
write_en  input  1  writeback strobe
write_addr  input  ADDR_W  writeback destination
write_data  input  DATA_W  writeback value
read_addr1  input  ADDR_W  read port 1 address
read_addr2  input  ADDR_W  read port 2 address
read_data1  output  DATA_W  read port 1 data (combinational)
read_data2  output  DATA_W  read port 2 data (combinational)
reserve_en  input  1  mark reserve_addr busy (instruction issued with this destination)
reserve_addr  input  ADDR_W  register to reserve
busy1  output  1  read_addr1 has a pending writeback
busy2  output  1  read_addr2 has a pending writeback
reserve_err  output  1  registered; 1-cycle pulse when reserve_en targets an already-busy register

Behaviour:
- Reset (asynchronous, rst=1): all registers = 0, all busy bits = 0, reserve_err = 0. Reads therefore return 0 and busy1/busy2 = 0 while rst is held.
- Write: on posedge clk with write_en=1, mem[write_addr] <= write_data and busy[write_addr] <= 0. With ZERO_REG=1 and write_addr=0, the write is dropped.
- Read: read_dataN = mem[read_addrN] combinationally, zero latency.
- Bypass: if write_en=1 and write_addr==read_addrN, read_dataN = write_data in the same cycle. Not applied to R0 when ZERO_REG=1.
- Read R0 with ZERO_REG=1: always returns 0.
- Both read ports may address the same register; each returns identical data.
- Busy outputs: busyN = busy[read_addrN], forced to 0 when a same-cycle write (write_en=1, write_addr==read_addrN) is bypassing. Always 0 for R0 when ZERO_REG=1.
- Reserve: on posedge clk with reserve_en=1, busy[reserve_addr] <= 1. With ZERO_REG=1 and reserve_addr=0, the reserve is ignored.
- Reserve and write to the same address in the same cycle: the data is written and the busy bit ends at 1. Set has priority over clear, because the new reservation belongs to a younger instruction.
- reserve_err: next cycle = reserve_en & busy[reserve_addr] & ~(write_en & write_addr==reserve_addr). The reserve still takes effect (busy stays 1). Pulses for exactly one cycle per offending request.
- Reset asserted mid-operation clears all state immediately, including busy bits and any reserve_err pulse in progress.
- No other internal state; no handshake stalls. The block always accepts write_en and reserve_en.

Optional Feature:
Macro REG_FILE_STATS_EN.
- Defined: adds output port wb_count [15:0], a saturating count of accepted writes (dropped R0 writes excluded). Reset to 0 by rst; holds at 16'hFFFF once reached.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then read: assert rst, write_en=1 -> read_data1/2=0, busy1/2=0, no write takes effect while rst=1.
- Write/read/bypass: write R3=35, next cycle read R3 -> 35. Same cycle, write R4=47 with read_addr1=4 -> read_data1=47 before the edge.
- R0 (ZERO_REG=1): write R0=16'hBEEF and reserve R0 -> read R0=0, busy=0, reserve_err=0.
- Scoreboard: reserve R5 -> busy for R5=1 from next cycle. Write R5=256 -> busy1=0 in the write cycle (bypass) and stays 0 afterwards. A second reserve of R5 while busy -> reserve_err=1 for exactly one cycle.
- Same-cycle reserve+write R6: write 16'h1234 with reserve_en R6 -> mem[6]=16'h1234, busy[6]=1, reserve_err=0.
- Mid-operation reset: reserve R2 and R7, write R2=9, pulse rst asynchronously between edges -> all busy bits 0 immediately, R2 reads 0; with REG_FILE_STATS_EN, wb_count returns to 0.
